alu_apply_sequencer: RTL and testbench

Sequential front end that drives the combinational ALU on behalf of the evaluator when it applies a variadic Lisp primitive such as `(+ a b c)` or `(< a b c)`. It accepts a command (opcode, argument count) and then a stream of arguments over valid/ready handshakes. It folds the arguments through the ALU one per cycle and returns a single result word with an error flag. It sits between the evaluator's apply stage and the ALU instance, and is the only driver of the ALU's `in_0`, `in_1` and `opcode` inputs.

---
 rtl/alu_apply_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_apply_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_apply_sequencer.sv
// alu_apply_sequencer
//   Front end that drives the combinational ALU for a variadic primitive
//   application such as (+ a b c) or (< a b c). A command (opcode, argc) is
//   taken first, then argc arguments are folded through the ALU one per cycle.
//   A single result word and an error flag are returned.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_opcode, cmd_argc           primitive opcode, argument count (0..15)
//   arg_valid/arg_ready, arg_data  argument stream
//   alu_in_0, alu_in_1, alu_opcode drive of the shared ALU instance
//   alu_result                     combinational ALU output, same cycle
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_error            folded result, illegal-command flag

`ifndef ALU_DATA_WIDTH
`define ALU_DATA_WIDTH 16
`endif
`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 4
`endif
`ifndef SYS_ADD
`define SYS_ADD     4'd0
`define SYS_SUB     4'd1
`define SYS_AND     4'd2
`define SYS_OR      4'd3
`define SYS_NOT     4'd4
`define SYS_LESS    4'd5
`define SYS_GREATER 4'd6
`define SYS_EQUAL   4'd7
`endif

module alu_apply_sequencer #(
  parameter int DATA_WIDTH = `ALU_DATA_WIDTH,
  parameter int OP_WIDTH   = `ALU_OPCODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_WIDTH-1:0]   cmd_opcode,
  input  logic [3:0]            cmd_argc,
  input  logic                  arg_valid,
  output logic                  arg_ready,
  input  logic [DATA_WIDTH-1:0] arg_data,
  output logic [DATA_WIDTH-1:0] alu_in_0,
  output logic [DATA_WIDTH-1:0] alu_in_1,
  output logic [OP_WIDTH-1:0]   alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error
);

  localparam logic [OP_WIDTH-1:0] OP_ADD     = OP_WIDTH'(`SYS_ADD);
  localparam logic [OP_WIDTH-1:0] OP_SUB     = OP_WIDTH'(`SYS_SUB);
  localparam logic [OP_WIDTH-1:0] OP_AND     = OP_WIDTH'(`SYS_AND);
  localparam logic [OP_WIDTH-1:0] OP_OR      = OP_WIDTH'(`SYS_OR);
  localparam logic [OP_WIDTH-1:0] OP_NOT     = OP_WIDTH'(`SYS_NOT);
  localparam logic [OP_WIDTH-1:0] OP_LESS    = OP_WIDTH'(`SYS_LESS);
  localparam logic [OP_WIDTH-1:0] OP_GREATER = OP_WIDTH'(`SYS_GREATER);
  localparam logic [OP_WIDTH-1:0] OP_EQUAL   = OP_WIDTH'(`SYS_EQUAL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_ACCUM = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [OP_WIDTH-1:0]   r_op;
  logic [3:0]            r_remaining;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_flag;
  logic                  r_err;

  logic w_cmd_fire;
  logic w_arg_fire;
  logic w_is_cmp;
  logic w_cmd_legal;
  logic w_first_neg;
  logic w_first_not;

  assign w_cmd_fire  = cmd_valid & cmd_ready;
  assign w_arg_fire  = arg_valid & arg_ready;
  assign w_is_cmp    = r_op inside {OP_LESS, OP_GREATER, OP_EQUAL};
  assign w_cmd_legal = cmd_opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                          OP_NOT, OP_LESS, OP_GREATER, OP_EQUAL};
  // Single-argument forms that need the ALU on the first argument:
  // unary minus (0 - a) and logical not. In FIRST, r_remaining still equals argc.
  assign w_first_neg = (r_op == OP_SUB) && (r_remaining == 4'd1);
  assign w_first_not = (r_op == OP_NOT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Handshake outputs are decoded from state and forced low during reset so
  // nothing offered in a reset cycle is ever accepted.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    arg_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_in_0    = '0;
    alu_in_1    = '0;
    alu_opcode  = '0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid) w_state_nxt = (cmd_argc == 4'd0) ? S_RESP : S_FIRST;
      end
      S_FIRST: begin
        arg_ready = ~rst;
        if (w_first_neg) begin
          alu_in_1   = arg_data;
          alu_opcode = OP_SUB;
        end else if (w_first_not) begin
          alu_in_0   = arg_data;
          alu_opcode = OP_NOT;
        end
        if (arg_valid) w_state_nxt = (r_remaining == 4'd1) ? S_RESP : S_ACCUM;
      end
      S_ACCUM: begin
        arg_ready  = ~rst;
        alu_opcode = r_op;
        // Compare chains test adjacent pairs; other ops fold into acc.
        alu_in_0   = w_is_cmp ? r_prev : r_acc;
        alu_in_1   = arg_data;
        if (arg_valid && (r_remaining == 4'd1)) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = ~rst;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_remaining <= '0;
      r_acc       <= '0;
      r_prev      <= '0;
      r_flag      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_op        <= cmd_opcode;
        r_remaining <= cmd_argc;
        r_err       <= (cmd_argc == 4'd0) || !w_cmd_legal ||
                       ((cmd_opcode == OP_NOT) && (cmd_argc > 4'd1));
      end
      if (w_arg_fire) begin
        r_remaining <= r_remaining - 4'd1;
        if (r_state == S_FIRST) begin
          r_prev <= arg_data;
          r_flag <= 1'b1;
          r_acc  <= (w_first_neg || w_first_not) ? alu_result : arg_data;
        end else if (w_is_cmp) begin
          r_flag <= r_flag & alu_result[0];
          r_prev <= arg_data;
        end else begin
          r_acc  <= alu_result;
        end
      end
    end
  end

  // Response registers do not move in RESP, so data/error hold until taken.
  assign rsp_data  = r_err    ? '0 :
                     w_is_cmp ? {{(DATA_WIDTH-1){1'b0}}, r_flag} : r_acc;
  assign rsp_error = r_err;

endmodule

// File: tb/tb_alu_apply_sequencer.sv
`ifndef ALU_DATA_WIDTH
`define ALU_DATA_WIDTH 16
`endif
`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 4
`endif
`ifndef SYS_ADD
`define SYS_ADD     4'd0
`define SYS_SUB     4'd1
`define SYS_AND     4'd2
`define SYS_OR      4'd3
`define SYS_NOT     4'd4
`define SYS_LESS    4'd5
`define SYS_GREATER 4'd6
`define SYS_EQUAL   4'd7
`endif

module tb_alu_apply_sequencer;

  localparam logic [3:0] OP_ADD     = `SYS_ADD;
  localparam logic [3:0] OP_SUB     = `SYS_SUB;
  localparam logic [3:0] OP_AND     = `SYS_AND;
  localparam logic [3:0] OP_OR      = `SYS_OR;
  localparam logic [3:0] OP_NOT     = `SYS_NOT;
  localparam logic [3:0] OP_LESS    = `SYS_LESS;
  localparam logic [3:0] OP_GREATER = `SYS_GREATER;
  localparam logic [3:0] OP_EQUAL   = `SYS_EQUAL;
  localparam int         TMO        = 50;

  typedef logic [15:0] arr_t [16];

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [3:0]  cmd_argc;
  logic        arg_valid;
  logic        arg_ready;
  logic [15:0] arg_data;
  logic [15:0] alu_in_0;
  logic [15:0] alu_in_1;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_error;

  int n_tests = 0;
  int n_fail  = 0;
  int n_arg   = 0;
  int n_rsp   = 0;

  alu_apply_sequencer #(.DATA_WIDTH(16), .OP_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_argc(cmd_argc),
    .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
    .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_error(rsp_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the combinational ALU (unsigned compares).
  always_comb begin
    alu_result = 16'h0000;
    case (alu_opcode)
      OP_ADD:     alu_result = alu_in_0 + alu_in_1;
      OP_SUB:     alu_result = alu_in_0 - alu_in_1;
      OP_AND:     alu_result = alu_in_0 & alu_in_1;
      OP_OR:      alu_result = alu_in_0 | alu_in_1;
      OP_NOT:     alu_result = ~alu_in_0;
      OP_LESS:    alu_result = {15'd0, alu_in_0 < alu_in_1};
      OP_GREATER: alu_result = {15'd0, alu_in_0 > alu_in_1};
      OP_EQUAL:   alu_result = {15'd0, alu_in_0 == alu_in_1};
      default:    alu_result = 16'h0000;
    endcase
  end

  always @(posedge clk) begin
    if (!rst && arg_valid && arg_ready) n_arg++;
    if (!rst && rsp_valid && rsp_ready) n_rsp++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if ($countones({cmd_ready, arg_ready, rsp_valid}) > 1) begin
        n_fail++;
        $display("FAIL ready_exclusive: cmd_ready=%b arg_ready=%b rsp_valid=%b required at most one high",
                 cmd_ready, arg_ready, rsp_valid);
      end
    end
  end

  // Reference: result of applying the primitive to the whole argument list.
  function automatic logic [16:0] model(input logic [3:0] op, input int argc, input arr_t a);
    logic [15:0] r;
    logic [15:0] s;
    logic        ok;
    r = 16'h0000; s = 16'h0000; ok = 1'b1;
    if (argc == 0 || !(op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
                                  OP_LESS, OP_GREATER, OP_EQUAL}) ||
        (op == OP_NOT && argc > 1))
      return {1'b1, 16'h0000};
    case (op)
      OP_ADD: for (int i = 0; i < argc; i++) r = r + a[i];
      OP_SUB: begin
        if (argc == 1) r = 16'h0000 - a[0];
        else begin
          for (int i = 1; i < argc; i++) s = s + a[i];
          r = a[0] - s;
        end
      end
      OP_AND: begin r = 16'hFFFF; for (int i = 0; i < argc; i++) r = r & a[i]; end
      OP_OR:  for (int i = 0; i < argc; i++) r = r | a[i];
      OP_NOT: r = ~a[0];
      default: begin
        for (int i = 0; i + 1 < argc; i++) begin
          if (op == OP_LESS    && !(a[i] <  a[i+1])) ok = 1'b0;
          if (op == OP_GREATER && !(a[i] >  a[i+1])) ok = 1'b0;
          if (op == OP_EQUAL   && !(a[i] == a[i+1])) ok = 1'b0;
        end
        r = {15'd0, ok};
      end
    endcase
    return {1'b0, r};
  endfunction

  task automatic send_cmd(input logic [3:0] op, input logic [3:0] argc, output logic to);
    int n;
    to = 1'b0; n = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_argc = argc;
    while (cmd_ready !== 1'b1) begin
      if (n == TMO) begin to = 1'b1; cmd_valid = 1'b0; return; end
      @(negedge clk); n++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_arg(input logic [15:0] d, output logic to);
    int n;
    to = 1'b0; n = 0;
    arg_valid = 1'b1; arg_data = d;
    while (arg_ready !== 1'b1) begin
      if (n == TMO) begin to = 1'b1; arg_valid = 1'b0; return; end
      @(negedge clk); n++;
    end
    @(posedge clk);
    @(negedge clk);
    arg_valid = 1'b0;
  endtask

  task automatic get_rsp(input int delay, output logic [15:0] d, output logic e,
                         output logic stable_ok, output logic back_ok, output logic to);
    int n;
    to = 1'b0; n = 0; stable_ok = 1'b1; back_ok = 1'b0; d = 16'h0; e = 1'b0;
    rsp_ready = (delay == 0);
    while (rsp_valid !== 1'b1) begin
      if (n == TMO) begin to = 1'b1; rsp_ready = 1'b0; return; end
      @(negedge clk); n++;
    end
    d = rsp_data; e = rsp_error;
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_error !== e || cmd_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    back_ok = (cmd_ready === 1'b1);
  endtask

  task automatic run_cmd(input logic [3:0] op, input int argc, input arr_t a,
                         input int gap_at, input int gap_len, input int delay,
                         output logic [15:0] d, output logic e, output logic lat_ok,
                         output logic stable_ok, output logic back_ok, output logic to);
    lat_ok = 1'b0; stable_ok = 1'b0; back_ok = 1'b0; d = 16'h0; e = 1'b0;
    send_cmd(op, argc[3:0], to);
    if (to) return;
    for (int i = 0; i < argc; i++) begin
      if (i == gap_at) repeat (gap_len) @(negedge clk);
      send_arg(a[i], to);
      if (to) return;
    end
    lat_ok = (rsp_valid === 1'b1);
    get_rsp(delay, d, e, stable_ok, back_ok, to);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_argc = 4'd2;
    arg_valid = 1'b1; arg_data = 16'h1234; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_tests++;
    if (arg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_arg_ready: got %b want 0", arg_ready); end
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    rst = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_idle: cmd_ready got %b want 1", cmd_ready); end
    cmd_valid = 1'b0; arg_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fold_add();
    arr_t a; logic [15:0] d; logic e, lat, st, bk, to; int n0;
    a = '{default: 16'h0}; a[0] = 16'd3; a[1] = 16'd4; a[2] = 16'd5;
    n0 = n_arg;
    run_cmd(OP_ADD, 3, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL fold_add_timeout: handshake never completed"); return; end
    n_tests++;
    if (d !== 16'd12) begin n_fail++; $display("FAIL fold_add_data: got %0d want 12", d); end
    n_tests++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL fold_add_err: got %b want 0", e); end
    n_tests++;
    if (lat !== 1'b1) begin n_fail++; $display("FAIL fold_add_latency: rsp_valid got %b want 1 one cycle after last arg", lat); end
    n_tests++;
    if (bk !== 1'b1) begin n_fail++; $display("FAIL fold_add_cmd_ready_back: got %b want 1", bk); end
    n_tests++;
    if (n_arg - n0 != 3) begin n_fail++; $display("FAIL fold_add_args: consumed %0d want 3", n_arg - n0); end
  endtask

  task automatic test_negate_wrap();
    arr_t a; logic [15:0] d; logic e, lat, st, bk, to;
    a = '{default: 16'h0}; a[0] = 16'd5;
    run_cmd(OP_SUB, 1, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || d !== 16'hFFFB || e !== 1'b0) begin
      n_fail++; $display("FAIL negate: got data=%h err=%b to=%b want data=fffb err=0", d, e, to);
    end
    a[0] = 16'hFFFF; a[1] = 16'd2;
    run_cmd(OP_ADD, 2, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || d !== 16'h0001 || e !== 1'b0) begin
      n_fail++; $display("FAIL add_wrap: got data=%h err=%b to=%b want data=0001 err=0", d, e, to);
    end
  endtask

  task automatic test_compare();
    arr_t a; logic [15:0] d; logic e, lat, st, bk, to; int n0;
    a = '{default: 16'h0}; a[0] = 16'd1; a[1] = 16'd2; a[2] = 16'd3;
    run_cmd(OP_LESS, 3, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || d !== 16'd1 || e !== 1'b0) begin
      n_fail++; $display("FAIL less_123: got data=%h err=%b to=%b want data=1 err=0", d, e, to);
    end
    a[1] = 16'd3; a[2] = 16'd2;
    n0 = n_arg;
    run_cmd(OP_LESS, 3, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || d !== 16'd0 || e !== 1'b0) begin
      n_fail++; $display("FAIL less_132: got data=%h err=%b to=%b want data=0 err=0", d, e, to);
    end
    n_tests++;
    if (n_arg - n0 != 3) begin n_fail++; $display("FAIL less_132_args: consumed %0d want 3", n_arg - n0); end
    a[0] = 16'hBEEF;
    run_cmd(OP_EQUAL, 1, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || d !== 16'd1 || e !== 1'b0) begin
      n_fail++; $display("FAIL equal_single: got data=%h err=%b to=%b want data=1 err=0", d, e, to);
    end
    a[0] = 16'd9; a[1] = 16'd4; a[2] = 16'd4;
    run_cmd(OP_GREATER, 3, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || d !== 16'd0 || e !== 1'b0) begin
      n_fail++; $display("FAIL greater_944: got data=%h err=%b to=%b want data=0 err=0", d, e, to);
    end
  endtask

  task automatic test_errors();
    arr_t a; logic [15:0] d; logic e, lat, st, bk, to; int n0; logic saw_arg;
    a = '{default: 16'h0}; a[0] = 16'd1; a[1] = 16'd2;
    n0 = n_arg;
    run_cmd(OP_NOT, 2, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || d !== 16'd0 || e !== 1'b1) begin
      n_fail++; $display("FAIL not_argc2: got data=%h err=%b to=%b want data=0 err=1", d, e, to);
    end
    n_tests++;
    if (n_arg - n0 != 2) begin n_fail++; $display("FAIL not_argc2_args: consumed %0d want 2", n_arg - n0); end
    n0 = n_arg;
    run_cmd(4'd9, 2, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || d !== 16'd0 || e !== 1'b1 || n_arg - n0 != 2) begin
      n_fail++; $display("FAIL bad_opcode: got data=%h err=%b args=%0d want data=0 err=1 args=2", d, e, n_arg - n0);
    end
    // argc 0: response the cycle after the command, argument channel idle.
    send_cmd(OP_ADD, 4'd0, to);
    saw_arg = (arg_ready === 1'b1);
    n_tests++;
    if (to || rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL argc0_latency: rsp_valid got %b to=%b want 1", rsp_valid, to);
    end
    get_rsp(0, d, e, st, bk, to);
    n_tests++;
    if (to || d !== 16'd0 || e !== 1'b1) begin
      n_fail++; $display("FAIL argc0_rsp: got data=%h err=%b to=%b want data=0 err=1", d, e, to);
    end
    n_tests++;
    if (saw_arg) begin n_fail++; $display("FAIL argc0_arg_ready: got 1 want 0"); end
  endtask

  task automatic test_backpressure();
    arr_t a; logic [15:0] d; logic e, lat, st, bk, to; logic [16:0] exp_v;
    a = '{default: 16'h0};
    for (int i = 0; i < 4; i++) a[i] = 16'($urandom);
    exp_v = model(OP_ADD, 4, a);
    run_cmd(OP_ADD, 4, a, 2, 3, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || {e, d} !== exp_v) begin
      n_fail++; $display("FAIL arg_stall: got err=%b data=%h want err=%b data=%h", e, d, exp_v[16], exp_v[15:0]);
    end
    a[0] = 16'hF0F3; a[1] = 16'h3C3F;
    exp_v = model(OP_AND, 2, a);
    run_cmd(OP_AND, 2, a, -1, 0, 5, d, e, lat, st, bk, to);
    n_tests++;
    if (to || {e, d} !== exp_v) begin
      n_fail++; $display("FAIL rsp_stall_data: got err=%b data=%h want err=%b data=%h", e, d, exp_v[16], exp_v[15:0]);
    end
    n_tests++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL rsp_stall_stable: got %b want 1", st); end
    n_tests++;
    if (bk !== 1'b1) begin n_fail++; $display("FAIL rsp_stall_cmd_back: got %b want 1", bk); end
  endtask

  task automatic test_reset_mid();
    arr_t a; logic [15:0] d; logic e, lat, st, bk, to; int r0; logic quiet;
    send_cmd(OP_ADD, 4'd4, to);
    if (!to) send_arg(16'd100, to);
    if (!to) send_arg(16'd200, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL reset_mid_setup: handshake timeout"); return; end
    r0 = n_rsp;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || arg_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_idle: cmd_ready=%b arg_ready=%b want 1,0", cmd_ready, arg_ready);
    end
    quiet = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    rsp_ready = 1'b0;
    n_tests++;
    if (!quiet || n_rsp != r0) begin
      n_fail++; $display("FAIL reset_mid_no_rsp: responses %0d want 0", n_rsp - r0);
    end
    a = '{default: 16'h0}; a[0] = 16'd7; a[1] = 16'd8;
    run_cmd(OP_ADD, 2, a, -1, 0, 0, d, e, lat, st, bk, to);
    n_tests++;
    if (to || d !== 16'd15 || e !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_next: got data=%h err=%b to=%b want data=15 err=0", d, e, to);
    end
  endtask

  task automatic test_random();
    arr_t a; logic [15:0] d; logic e, lat, st, bk, to; logic [16:0] exp_v;
    logic [3:0] op; int argc; int gap_at; int gap_len; int delay; int n0;
    for (int it = 0; it < 40; it++) begin
      op      = 4'($urandom_range(0, 9));
      argc    = $urandom_range(0, 6);
      gap_at  = $urandom_range(0, 6);
      gap_len = $urandom_range(0, 2);
      delay   = $urandom_range(0, 2);
      a = '{default: 16'h0};
      for (int i = 0; i < argc; i++)
        a[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
      exp_v = model(op, argc, a);
      n0 = n_arg;
      run_cmd(op, argc, a, gap_at, gap_len, delay, d, e, lat, st, bk, to);
      n_tests++;
      if (to || {e, d} !== exp_v) begin
        n_fail++;
        $display("FAIL random_%0d: op=%0d argc=%0d got err=%b data=%h want err=%b data=%h to=%b",
                 it, op, argc, e, d, exp_v[16], exp_v[15:0], to);
      end
      n_tests++;
      if (lat !== 1'b1 || st !== 1'b1 || bk !== 1'b1 || n_arg - n0 != argc) begin
        n_fail++;
        $display("FAIL random_timing_%0d: lat=%b stable=%b back=%b args=%0d want 1,1,1,%0d",
                 it, lat, st, bk, n_arg - n0, argc);
      end
      if (to) break;
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 4'd0; cmd_argc = 4'd0;
    arg_valid = 1'b0; arg_data = 16'h0; rsp_ready = 1'b0;
    test_reset();
    test_fold_add();
    test_negate_wrap();
    test_compare();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
